uart_mem_bridge: RTL and testbench

UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

---
 rtl/uart_mem_pkg.sv | 73 +++++++
 rtl/uart_mem_bridge_if.sv | 40 ++++
 rtl/uart_mem_rd_stream.sv | 141 ++++++++++++++
 rtl/uart_mem_bridge.sv | 131 +++++++++++++
 tb/tb_uart_mem_bridge.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared types and constants for the UART memory bridge.
//   - address widths for the instruction RAM (8) and image RAM (19)
//   - default values for the bridge parameters
//   - load/run FSM states, read-stream sequencer states and the 3-bit
//     debug encoding shown on state_dbg
// Optional feature macro: UART_MEM_BRIDGE_CHECKSUM_EN adds the RD_TX_SUM state.
package uart_mem_pkg;

  localparam int unsigned INS_AW = 8;
  localparam int unsigned IMG_AW = 19;

  localparam int unsigned INS_LEN_DEF      = 256;
  localparam int unsigned IMG_IN_LEN_DEF   = 65536;
  localparam int unsigned IMG_OUT_BASE_DEF = 65536;
  localparam int unsigned IMG_OUT_LEN_DEF  = 16384;
  localparam int unsigned RD_LAT_DEF       = 2;

  // Debug encodings of the externally visible states.
  localparam logic [2:0] DBG_LOAD_INS = 3'd0;
  localparam logic [2:0] DBG_LOAD_IMG = 3'd1;
  localparam logic [2:0] DBG_RUN      = 3'd2;
  localparam logic [2:0] DBG_WAIT_CPU = 3'd3;
  localparam logic [2:0] DBG_RD_ADDR  = 3'd4;
  localparam logic [2:0] DBG_RD_WAIT  = 3'd5;
  localparam logic [2:0] DBG_TX       = 3'd6;
  localparam logic [2:0] DBG_DONE     = 3'd7;

  typedef enum logic [2:0] {
    T_LOAD_INS = 3'd0,
    T_LOAD_IMG = 3'd1,
    T_RUN      = 3'd2,
    T_WAIT_CPU = 3'd3,
    T_STREAM   = 3'd4,
    T_DONE     = 3'd7
  } top_state_e;

  typedef enum logic [2:0] {
    RD_IDLE   = 3'd0,
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    RD_TX_SUM = 3'd1,
`endif
    RD_ADDR   = 3'd4,
    RD_WAIT   = 3'd5,
    RD_TX     = 3'd6
  } rd_state_e;

  // While streaming, the visible state is the sequencer's phase. The
  // checksum byte is shown as TX since only eight codes fit in 3 bits.
  function automatic logic [2:0] dbg_code(input top_state_e top, input rd_state_e rd);
    logic [2:0] code;
    code = DBG_LOAD_INS;
    case (top)
      T_LOAD_INS: code = DBG_LOAD_INS;
      T_LOAD_IMG: code = DBG_LOAD_IMG;
      T_RUN:      code = DBG_RUN;
      T_WAIT_CPU: code = DBG_WAIT_CPU;
      T_DONE:     code = DBG_DONE;
      T_STREAM: begin
        case (rd)
          RD_WAIT:   code = DBG_RD_WAIT;
          RD_TX:     code = DBG_TX;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          RD_TX_SUM: code = DBG_TX;
`endif
          default:   code = DBG_RD_ADDR;
        endcase
      end
      default: code = DBG_LOAD_INS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/uart_mem_bridge_if.sv
// uart_mem_bridge_if: signal bundle between the bridge and its environment.
//   UART rx : rx_data, rx_valid (one-cycle strobe)
//   UART tx : tx_data, tx_start (one-cycle strobe), tx_ready (transmitter idle)
//   Instr RAM port b : ins_data, ins_addr, ins_we
//   Image RAM port b : img_data, img_addr, img_we, img_q (read data)
//   CPU : cpu_start (launch pulse), cpu_done (level or pulse)
//   Debug : state_dbg
// master = bridge side, slave = environment side.
interface uart_mem_bridge_if;
  import uart_mem_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic [7:0]        ins_data;
  logic [INS_AW-1:0] ins_addr;
  logic              ins_we;
  logic [7:0]        img_data;
  logic [IMG_AW-1:0] img_addr;
  logic              img_we;
  logic [7:0]        img_q;
  logic              cpu_start;
  logic              cpu_done;
  logic [2:0]        state_dbg;

  modport master (
    input  rx_data, rx_valid, tx_ready, img_q, cpu_done,
    output tx_data, tx_start, ins_data, ins_addr, ins_we,
           img_data, img_addr, img_we, cpu_start, state_dbg
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, img_q, cpu_done,
    input  tx_data, tx_start, ins_data, ins_addr, ins_we,
           img_data, img_addr, img_we, cpu_start, state_dbg
  );

endinterface

// File: rtl/uart_mem_rd_stream.sv
// uart_mem_rd_stream: reads IMG_OUT_LEN result bytes from image RAM starting
// at IMG_OUT_BASE and sends each one over the UART transmitter.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : one-cycle launch (from the load/run FSM)
//   done_o        : one-cycle, high in the cycle the final byte is sent
//   img_addr_o    : image RAM read address (0 when not reading)
//   img_q_i       : image RAM read data, valid RD_LAT cycles after the address
//   tx_data_o     : registered byte to send
//   tx_start_o    : send strobe, only while tx_ready_i is high
//   tx_ready_i    : transmitter idle
//   phase_o       : current sequencer state
// Optional feature macro: UART_MEM_BRIDGE_CHECKSUM_EN appends a modulo-256
// sum of all result bytes as one extra transmitted byte.
module uart_mem_rd_stream
  import uart_mem_pkg::*;
#(
  parameter int unsigned IMG_OUT_BASE = IMG_OUT_BASE_DEF,
  parameter int unsigned IMG_OUT_LEN  = IMG_OUT_LEN_DEF,
  parameter int unsigned RD_LAT       = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              done_o,
  output logic [IMG_AW-1:0] img_addr_o,
  input  logic [7:0]        img_q_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_ready_i,
  output rd_state_e         phase_o
);

  localparam logic [IMG_AW-1:0] BASE     = IMG_AW'(IMG_OUT_BASE);
  localparam logic [IMG_AW-1:0] LAST     = IMG_AW'(IMG_OUT_LEN - 1);
  localparam int unsigned       LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0]     LAT_LAST = LW'(RD_LAT - 1);

  rd_state_e         state_q, state_d;
  logic [IMG_AW-1:0] count_q, count_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [7:0]        tx_data_q, tx_data_d;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RD_IDLE;
      count_q   <= '0;
      lat_q     <= '0;
      tx_data_q <= '0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lat_q     <= lat_d;
      tx_data_q <= tx_data_d;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lat_d      = lat_q;
    tx_data_d  = tx_data_q;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    img_addr_o = '0;
    tx_start_o = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          count_d = '0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        // Sum wraps at 19 bits by construction.
        img_addr_o = BASE + count_q;
        lat_d      = '0;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        // Address stays on the bus for RD_LAT cycles; data is captured at
        // the end of the last one.
        img_addr_o = BASE + count_q;
        if (lat_q == LAT_LAST) begin
          tx_data_d = img_q_i;
          state_d   = RD_TX;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      RD_TX: begin
        if (tx_ready_i) begin
          tx_start_o = 1'b1;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          sum_d      = sum_q + tx_data_q;
`endif
          if (count_q == LAST) begin
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
            tx_data_d = sum_q + tx_data_q;
            state_d   = RD_TX_SUM;
`else
            done_o    = 1'b1;
            state_d   = RD_IDLE;
`endif
          end else begin
            count_d = count_q + IMG_AW'(1);
            state_d = RD_ADDR;
          end
        end
      end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
      RD_TX_SUM: begin
        if (tx_ready_i) begin
          tx_start_o = 1'b1;
          done_o     = 1'b1;
          state_d    = RD_IDLE;
        end
      end
`endif
      default: state_d = RD_IDLE;
    endcase
  end

  assign tx_data_o = tx_data_q;
  assign phase_o   = state_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: loads an instruction image and an input image from the
// UART into two RAMs, launches the CPU, waits for it, then streams the
// result region of the image RAM back over the UART. Repeats per job.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset, dominates all inputs
//   bus  : uart_mem_bridge_if.master (UART rx/tx, instr RAM port b,
//          image RAM port b, CPU start/done, state_dbg)
// Optional feature macro: UART_MEM_BRIDGE_CHECKSUM_EN (see uart_mem_rd_stream).
module uart_mem_bridge
  import uart_mem_pkg::*;
#(
  parameter int unsigned INS_LEN      = INS_LEN_DEF,
  parameter int unsigned IMG_IN_LEN   = IMG_IN_LEN_DEF,
  parameter int unsigned IMG_OUT_BASE = IMG_OUT_BASE_DEF,
  parameter int unsigned IMG_OUT_LEN  = IMG_OUT_LEN_DEF,
  parameter int unsigned RD_LAT       = RD_LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  uart_mem_bridge_if.master bus
);

  localparam logic [IMG_AW-1:0] INS_LAST = IMG_AW'(INS_LEN - 1);
  localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_IN_LEN - 1);

  top_state_e        state_q, state_d;
  logic [IMG_AW-1:0] count_q, count_d;

  logic              rd_start;
  logic              rd_done;
  logic [IMG_AW-1:0] rd_addr;
  logic [7:0]        rd_tx_data;
  logic              rd_tx_start;
  rd_state_e         rd_phase;

  uart_mem_rd_stream #(
    .IMG_OUT_BASE (IMG_OUT_BASE),
    .IMG_OUT_LEN  (IMG_OUT_LEN),
    .RD_LAT       (RD_LAT)
  ) u_rd_stream (
    .clk        (clk),
    .rst        (rst),
    .start_i    (rd_start),
    .done_o     (rd_done),
    .img_addr_o (rd_addr),
    .img_q_i    (bus.img_q),
    .tx_data_o  (rd_tx_data),
    .tx_start_o (rd_tx_start),
    .tx_ready_i (bus.tx_ready),
    .phase_o    (rd_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_LOAD_INS;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_start      = 1'b0;
    bus.ins_we    = 1'b0;
    bus.ins_addr  = '0;
    bus.ins_data  = '0;
    bus.img_we    = 1'b0;
    bus.img_addr  = '0;
    bus.img_data  = '0;
    bus.cpu_start = 1'b0;

    case (state_q)
      T_LOAD_INS: begin
        bus.ins_addr = count_q[INS_AW-1:0];
        if (bus.rx_valid) begin
          bus.ins_we   = 1'b1;
          bus.ins_data = bus.rx_data;
          if (count_q == INS_LAST) begin
            count_d = '0;
            state_d = T_LOAD_IMG;
          end else begin
            count_d = count_q + IMG_AW'(1);
          end
        end
      end
      T_LOAD_IMG: begin
        bus.img_addr = count_q;
        if (bus.rx_valid) begin
          bus.img_we   = 1'b1;
          bus.img_data = bus.rx_data;
          if (count_q == IMG_LAST) begin
            count_d = '0;
            state_d = T_RUN;
          end else begin
            count_d = count_q + IMG_AW'(1);
          end
        end
      end
      T_RUN: begin
        bus.cpu_start = 1'b1;
        state_d       = T_WAIT_CPU;
      end
      T_WAIT_CPU: begin
        if (bus.cpu_done) begin
          rd_start = 1'b1;
          count_d  = '0;
          state_d  = T_STREAM;
        end
      end
      T_STREAM: begin
        bus.img_addr = rd_addr;
        if (rd_done) begin
          state_d = T_DONE;
        end
      end
      T_DONE: begin
        count_d = '0;
        state_d = T_LOAD_INS;
      end
      default: state_d = T_LOAD_INS;
    endcase
  end

  assign bus.tx_data   = rd_tx_data;
  assign bus.tx_start  = rd_tx_start;
  assign bus.state_dbg = dbg_code(state_q, rd_phase);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: scoreboard bench for uart_mem_bridge with a small
// configuration (4 instruction bytes, 4 image bytes, 3 result bytes at 8).
// Stimulus pushes expected RAM writes, CPU launches and transmitted bytes;
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_uart_mem_bridge;

  localparam int unsigned INS_LEN  = 4;
  localparam int unsigned IMG_LEN  = 4;
  localparam int unsigned OUT_BASE = 8;
  localparam int unsigned OUT_LEN  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_mem_bridge_if bus();

  uart_mem_bridge #(
    .INS_LEN      (INS_LEN),
    .IMG_IN_LEN   (IMG_LEN),
    .IMG_OUT_BASE (OUT_BASE),
    .IMG_OUT_LEN  (OUT_LEN),
    .RD_LAT       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_ins[$];
  wr_t exp_img[$];
  int  exp_tx[$];
  int  exp_cpu[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 0;  // 0: ready high, 1: ready low, 2: random

  logic [7:0] img_mem [0:31];
  logic [7:0] res_mem [0:7];
  logic [7:0] rd_p0, rd_p1;
  int         ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Image RAM model: result region served from res_mem, 2-cycle read latency.
  assign ra = int'(bus.img_addr);
  always @(posedge clk) begin
    if (bus.img_we === 1'b1) img_mem[ra % 32] <= bus.img_data;
    if (ra >= int'(OUT_BASE) && ra < int'(OUT_BASE + OUT_LEN)) rd_p0 <= res_mem[ra - int'(OUT_BASE)];
    else rd_p0 <= img_mem[ra % 32];
    rd_p1 <= rd_p0;
  end
  assign bus.img_q = rd_p1;

  // Transmitter-ready driver.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = 1'b0;
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  wr_t mw;
  int  mt;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.ins_we === 1'b1) begin
        chk("ins_we_expected", 32'(exp_ins.size() != 0), 1);
        chk("we_exclusive", 32'(bus.img_we), 0);
        if (exp_ins.size() != 0) begin
          mw = exp_ins.pop_front();
          chk("ins_addr", 32'(bus.ins_addr), mw.addr);
          chk("ins_data", 32'(bus.ins_data), mw.data);
        end
      end
      if (bus.img_we === 1'b1) begin
        chk("img_we_expected", 32'(exp_img.size() != 0), 1);
        if (exp_img.size() != 0) begin
          mw = exp_img.pop_front();
          chk("img_addr", 32'(bus.img_addr), mw.addr);
          chk("img_data", 32'(bus.img_data), mw.data);
        end
      end
      if (bus.tx_start === 1'b1) begin
        chk("tx_expected", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) begin
          mt = exp_tx.pop_front();
          chk("tx_data", 32'(bus.tx_data), mt);
        end
      end
      if (bus.cpu_start === 1'b1) begin
        chk("cpu_start_expected", 32'(exp_cpu.size() != 0), 1);
        if (exp_cpu.size() != 0) void'(exp_cpu.pop_front());
      end
    end
  end

  task automatic send_raw(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_data"},   32'(bus.tx_data), 0);
    chk({tag, "_tx_start"},  32'(bus.tx_start), 0);
    chk({tag, "_ins_we"},    32'(bus.ins_we), 0);
    chk({tag, "_ins_addr"},  32'(bus.ins_addr), 0);
    chk({tag, "_ins_data"},  32'(bus.ins_data), 0);
    chk({tag, "_img_we"},    32'(bus.img_we), 0);
    chk({tag, "_img_addr"},  32'(bus.img_addr), 0);
    chk({tag, "_img_data"},  32'(bus.img_data), 0);
    chk({tag, "_cpu_start"}, 32'(bus.cpu_start), 0);
    chk({tag, "_state_dbg"}, 32'(bus.state_dbg), 0);
  endtask

  task automatic load_bytes(input logic [7:0] ins_b [4], input logic [7:0] img_b [4], input int n_img);
    for (int i = 0; i < int'(INS_LEN); i++) begin
      exp_ins.push_back('{i, int'(ins_b[i])});
      send_raw(ins_b[i]);
    end
    for (int i = 0; i < n_img; i++) begin
      exp_img.push_back('{i, int'(img_b[i])});
      if (i == int'(IMG_LEN) - 1) exp_cpu.push_back(1);
      send_raw(img_b[i]);
    end
  endtask

  task automatic run_job(input logic [7:0] ins_b [4], input logic [7:0] img_b [4],
                         input logic [7:0] res_b [3], input bit stall, input int rmode);
    bit seen;
    int sum;
    load_bytes(ins_b, img_b, int'(IMG_LEN));

    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.cpu_start === 1'b1) seen = 1'b1;
    end
    chk("cpu_start_seen", 32'(seen), 1);

    // cpu_done coinciding with cpu_start must be ignored.
    bus.cpu_done = 1'b1;
    @(negedge clk);
    bus.cpu_done = 1'b0;
    chk("in_wait_cpu", 32'(bus.state_dbg), 3);

    // Bytes during WAIT_CPU must be dropped.
    send_raw(8'($urandom));
    send_raw(8'($urandom));
    repeat (3) @(negedge clk);
    chk("still_wait_cpu", 32'(bus.state_dbg), 3);

    sum = 0;
    for (int k = 0; k < int'(OUT_LEN); k++) res_mem[k] = res_b[k];
    ready_mode = stall ? 1 : rmode;
    @(posedge clk);
    #1;
    bus.cpu_done = 1'b1;
    for (int k = 0; k < int'(OUT_LEN); k++) begin
      exp_tx.push_back(int'(res_b[k]));
      sum = (sum + int'(res_b[k])) % 256;
    end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    exp_tx.push_back(sum);
`endif
    @(posedge clk);
    #1;
    bus.cpu_done = 1'b0;

    if (stall) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (bus.state_dbg === 3'd6) seen = 1'b1;
      end
      chk("stall_reached_tx", 32'(seen), 1);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("stall_no_tx_start", 32'(bus.tx_start), 0);
        chk("stall_tx_data_held", 32'(bus.tx_data), 32'(res_b[0]));
      end
      ready_mode = 0;
      @(negedge clk);
      chk("resume_tx_start", 32'(bus.tx_start), 1);
    end

    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (bus.state_dbg === 3'd7) seen = 1'b1;
    end
    chk("done_reached", 32'(seen), 1);
    chk("tx_all_sent", 32'(exp_tx.size()), 0);
    @(negedge clk);
    chk("back_to_load_ins", 32'(bus.state_dbg), 0);
    ready_mode = 0;
  endtask

  logic [7:0] a_ins [4];
  logic [7:0] a_img [4];
  logic [7:0] a_res [3];

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.cpu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");

    // Fixed job: known load bytes and result bytes 05,06,07.
    a_ins = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    a_res = '{8'h05, 8'h06, 8'h07};
    run_job(a_ins, a_img, a_res, 1'b0, 0);

    // Stalled transmitter, results F0,20,05 (sum 15).
    for (int i = 0; i < 4; i++) begin
      a_ins[i] = 8'($urandom);
      a_img[i] = 8'($urandom);
    end
    a_res = '{8'hF0, 8'h20, 8'h05};
    run_job(a_ins, a_img, a_res, 1'b1, 0);

    // Reset in LOAD_IMG after two image bytes.
    for (int i = 0; i < 4; i++) begin
      a_ins[i] = 8'($urandom);
      a_img[i] = 8'($urandom);
    end
    load_bytes(a_ins, a_img, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    chk("midrst_ins_q_empty", 32'(exp_ins.size()), 0);
    chk("midrst_img_q_empty", 32'(exp_img.size()), 0);

    // Randomized jobs with random transmitter readiness.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        a_ins[i] = 8'($urandom);
        a_img[i] = 8'($urandom);
      end
      for (int i = 0; i < 3; i++) a_res[i] = 8'($urandom);
      run_job(a_ins, a_img, a_res, 1'b0, 2);
    end

    repeat (5) @(negedge clk);
    chk("final_ins_q_empty", 32'(exp_ins.size()), 0);
    chk("final_img_q_empty", 32'(exp_img.size()), 0);
    chk("final_tx_q_empty",  32'(exp_tx.size()), 0);
    chk("final_cpu_q_empty", 32'(exp_cpu.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
